// File: rtl/ram_pkg.sv
// Shared types and helpers for the multi-read-port waveform RAM.
package ram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    typedef enum logic {
        RDW_OLD = 1'b0,
        RDW_NEW = 1'b1
    } rdw_mode_e;

    // Number of words addressed by an address of the given width.
    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'(1) << addr_width;
    endfunction

endpackage

// File: rtl/ram_mp_if.sv
// Write port, per-channel read ports and status of the multi-read-port RAM.
interface ram_mp_if #(
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned READ_PORTS    = 2
);

    logic                                wr_en;
    logic [ADDRESS_WIDTH-1:0]            wr_addr;
    logic [DATA_WIDTH-1:0]               wr_data;
    logic [READ_PORTS-1:0]               rd_en;
    logic [READ_PORTS*ADDRESS_WIDTH-1:0] rd_addr;
    logic [READ_PORTS*DATA_WIDTH-1:0]    rd_data;
    logic [READ_PORTS-1:0]               rd_valid;
    logic                                busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, busy
    );

endinterface

// File: rtl/ram_init_seq.sv
// Clear sequencer: sweeps every address once after reset, writing zero.
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     busy,
    output logic                     init_we_c,
    output logic [ADDRESS_WIDTH-1:0] init_addr
);

    state_t                   state;
    state_t                   state_d;
    logic [ADDRESS_WIDTH-1:0] count;
    logic [ADDRESS_WIDTH-1:0] count_d;
    logic                     busy_d;

    // State, sweep counter and busy flag; reset restarts the sweep at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (INIT_ON_RESET) begin
                state <= INIT;
            end else begin
                state <= READY;
            end
            count <= '0;
            busy  <= INIT_ON_RESET;
        end else begin
            state <= state_d;
            count <= count_d;
            busy  <= busy_d;
        end
    end

    // Advance the sweep; the write to the top address is the last one.
    always_comb begin
        state_d = state;
        count_d = count;
        busy_d  = 1'b0;
        case (state)
            INIT: begin
                count_d = count + ADDRESS_WIDTH'(1);
                if (count == '1) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = READY;
            end
        endcase
        busy_d = (state_d == INIT);
    end

    assign init_we_c = (state == INIT);
    assign init_addr = count;

endmodule

// File: rtl/ram_mp.sv
// One-write, multi-read synchronous RAM with clear-after-reset and optional output stage.
module ram_mp
    import ram_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned READ_PORTS    = 2,
    parameter int unsigned RDW_MODE      = 0,
    parameter int unsigned OUT_REG       = 0,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic     clk,
    input  logic     rst,
    ram_mp_if.slave  bus
);

    localparam int unsigned AW     = ADDRESS_WIDTH;
    localparam int unsigned DW     = DATA_WIDTH;
    localparam int unsigned RP     = READ_PORTS;
    localparam int unsigned DEPTH  = depth_of(ADDRESS_WIDTH);
    localparam bit          BYPASS = (RDW_MODE == 32'(RDW_NEW));

    logic          sweep_c;
    logic [AW-1:0] sweep_addr;
    logic          busy;

    ram_init_seq #(
        .ADDRESS_WIDTH (AW),
        .INIT_ON_RESET (INIT_ON_RESET != 0)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .init_we_c (sweep_c),
        .init_addr (sweep_addr)
    );

    assign bus.busy = busy;

    logic          mem_we_c;
    logic [AW-1:0] mem_waddr_c;
    logic [DW-1:0] mem_wdata_c;

    // Write mux: the sweep owns the port while clearing; external writes are dropped.
    always_comb begin
        mem_we_c    = bus.wr_en;
        mem_waddr_c = bus.wr_addr;
        mem_wdata_c = bus.wr_data;
        if (sweep_c) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = sweep_addr;
            mem_wdata_c = '0;
        end
    end

    logic [DW-1:0] mem [DEPTH];

    // Storage array; contents are defined by the sweep, so no reset here.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    for (genvar k = 0; k < RP; k++) begin : g_rd
        logic [AW-1:0] addr_c;
        logic          take_c;
        logic          hit_c;
        logic [DW-1:0] data_q;
        logic          valid_q;

        assign addr_c = bus.rd_addr[k*AW +: AW];
        assign take_c = bus.rd_en[k] && !sweep_c;
        assign hit_c  = BYPASS && mem_we_c && (mem_waddr_c == addr_c);

        // First read stage; data holds when the channel is not reading.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= take_c;
                if (take_c) begin
                    data_q <= hit_c ? mem_wdata_c : mem[addr_c];
                end
            end
        end

        if (OUT_REG != 0) begin : g_out
            logic [DW-1:0] data_qq;
            logic          valid_qq;

            // Extra output stage, valid travels with data.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_qq  <= '0;
                    valid_qq <= 1'b0;
                end else begin
                    data_qq  <= data_q;
                    valid_qq <= valid_q;
                end
            end

            assign bus.rd_data[k*DW +: DW] = data_qq;
            assign bus.rd_valid[k]         = valid_qq;
        end else begin : g_direct
            assign bus.rd_data[k*DW +: DW] = data_q;
            assign bus.rd_valid[k]         = valid_q;
        end
    end

endmodule

// File: tb/tb_ram_mp.sv
// Scoreboard bench: dut0 = old-data RDW, no output stage, cleared on reset;
// dut1 = new-data RDW, output stage, not cleared on reset.
module tb_ram_mp;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 8;
    localparam int unsigned RP    = 2;
    localparam int unsigned DEPTH = 512;

    typedef struct packed {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          s_rst   [2] = '{1'b0, 1'b0};
    logic          s_we    [2];
    logic [AW-1:0] s_waddr [2];
    logic [DW-1:0] s_wdata [2];
    logic          s_re    [2][RP];
    logic [AW-1:0] s_raddr [2][RP];

    logic          o_busy  [2];
    logic          o_valid [2][RP];
    logic [DW-1:0] o_data  [2][RP];
    logic          rst0;
    logic          rst1;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            rem [2] = '{0, 0};
    logic [DW-1:0] mdl  [2][DEPTH];
    logic [DW-1:0] last [2][RP];
    exp_t          sb   [4][$];

    ram_mp_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_PORTS(RP)) bus0 ();
    ram_mp_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_PORTS(RP)) bus1 ();

    ram_mp #(
        .ADDRESS_WIDTH (AW), .DATA_WIDTH (DW), .READ_PORTS (RP),
        .RDW_MODE (0), .OUT_REG (0), .INIT_ON_RESET (1)
    ) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    ram_mp #(
        .ADDRESS_WIDTH (AW), .DATA_WIDTH (DW), .READ_PORTS (RP),
        .RDW_MODE (1), .OUT_REG (1), .INIT_ON_RESET (0)
    ) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    assign rst0          = s_rst[0];
    assign rst1          = s_rst[1];
    assign bus0.wr_en    = s_we[0];
    assign bus0.wr_addr  = s_waddr[0];
    assign bus0.wr_data  = s_wdata[0];
    assign bus0.rd_en    = {s_re[0][1], s_re[0][0]};
    assign bus0.rd_addr  = {s_raddr[0][1], s_raddr[0][0]};
    assign bus1.wr_en    = s_we[1];
    assign bus1.wr_addr  = s_waddr[1];
    assign bus1.wr_data  = s_wdata[1];
    assign bus1.rd_en    = {s_re[1][1], s_re[1][0]};
    assign bus1.rd_addr  = {s_raddr[1][1], s_raddr[1][0]};

    assign o_busy[0]     = bus0.busy;
    assign o_busy[1]     = bus1.busy;
    assign o_valid[0][0] = bus0.rd_valid[0];
    assign o_valid[0][1] = bus0.rd_valid[1];
    assign o_valid[1][0] = bus1.rd_valid[0];
    assign o_valid[1][1] = bus1.rd_valid[1];
    assign o_data[0][0]  = bus0.rd_data[DW-1:0];
    assign o_data[0][1]  = bus0.rd_data[2*DW-1:DW];
    assign o_data[1][0]  = bus1.rd_data[DW-1:0];
    assign o_data[1][1]  = bus1.rd_data[2*DW-1:DW];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int id, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s id=%0d observed=%0h expected=%0h", tag, id, obs, expv);
        end
    endtask

    function automatic int lat(input bit d);
        return d ? 2 : 1;
    endfunction

    task automatic wr(input int d, input int a, input int v);
        s_we[1'(d)]    = 1'b1;
        s_waddr[1'(d)] = AW'(a);
        s_wdata[1'(d)] = DW'(v);
    endtask

    task automatic rd(input int d, input int k, input int a);
        s_re[1'(d)][1'(k)]    = 1'b1;
        s_raddr[1'(d)][1'(k)] = AW'(a);
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            s_we[1'(d)] = 1'b0;
            for (int k = 0; k < int'(RP); k++) s_re[1'(d)][1'(k)] = 1'b0;
        end
    endtask

    // Expected results of the stimulus presented for the coming edge.
    task automatic book(input int d);
        bit            db;
        exp_t          e;
        logic [AW-1:0] a;
        db = 1'(d);
        if (!s_rst[db]) begin
            if (rem[db] > 0) begin
                rem[db]--;
            end else begin
                for (int k = 0; k < int'(RP); k++) begin
                    if (s_re[db][1'(k)]) begin
                        a      = s_raddr[db][1'(k)];
                        e.data = (db && s_we[db] && s_waddr[db] == a) ? s_wdata[db] : mdl[db][a];
                        e.due  = cyc + lat(db);
                        sb[{db, 1'(k)}].push_back(e);
                    end
                end
                if (s_we[db]) mdl[db][s_waddr[db]] = s_wdata[db];
            end
        end
    endtask

    task automatic monitor(input int d);
        bit   db;
        bit   kb;
        exp_t e;
        db = 1'(d);
        chk("busy", d, 32'(o_busy[db]), (rem[db] > 0) ? 32'd1 : 32'd0);
        for (int k = 0; k < int'(RP); k++) begin
            kb = 1'(k);
            if (o_valid[db][kb]) begin
                checks++;
                assert (sb[{db, kb}].size() > 0) else begin
                    errors++;
                    $error("FAIL valid_unexpected id=%0d observed=1 expected=0", d * 10 + k);
                end
                if (sb[{db, kb}].size() > 0) begin
                    e = sb[{db, kb}].pop_front();
                    chk("rd_data", d * 10 + k, 32'(o_data[db][kb]), 32'(e.data));
                    chk("rd_latency", d * 10 + k, cyc, e.due);
                end
                last[db][kb] = o_data[db][kb];
            end else begin
                chk("rd_hold", d * 10 + k, 32'(o_data[db][kb]), 32'(last[db][kb]));
            end
        end
    endtask

    task automatic step();
        for (int d = 0; d < 2; d++) book(d);
        @(posedge clk);
        cyc++;
        #1;
        for (int d = 0; d < 2; d++) monitor(d);
        idle();
    endtask

    task automatic reset_duts(input logic [1:0] m, input int n);
        for (int d = 0; d < 2; d++) if (m[1'(d)]) s_rst[1'(d)] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (m[1'(d)]) begin
                for (int k = 0; k < int'(RP); k++) begin
                    sb[{1'(d), 1'(k)}].delete();
                    last[1'(d)][1'(k)] = '0;
                    chk("rst_valid", d * 10 + k, 32'(o_valid[1'(d)][1'(k)]), 32'd0);
                    chk("rst_data", d * 10 + k, 32'(o_data[1'(d)][1'(k)]), 32'd0);
                end
                rem[1'(d)] = (d == 0) ? int'(DEPTH) : 0;
                if (d == 0) for (int a = 0; a < int'(DEPTH); a++) mdl[0][AW'(a)] = '0;
                chk("rst_busy", d, 32'(o_busy[1'(d)]), (d == 0) ? 32'd1 : 32'd0);
            end
        end
        repeat (n) step();
        for (int d = 0; d < 2; d++) if (m[1'(d)]) s_rst[1'(d)] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            s_waddr[1'(d)] = '0;
            s_wdata[1'(d)] = '0;
            for (int k = 0; k < int'(RP); k++) s_raddr[1'(d)][1'(k)] = '0;
        end
        idle();
        #2;
        reset_duts(2'b11, 3);

        // dut1 is usable at once: basic, dual channel, read-during-write (new data).
        wr(1, 17, 8'h5C); step();
        rd(1, 0, 17); step();
        wr(1, 3, 8'h11); step();
        wr(1, 300, 8'hEE); step();
        rd(1, 0, 3); rd(1, 1, 300); step();
        wr(1, 5, 8'h01); step();
        wr(1, 5, 8'h02); rd(1, 0, 5); rd(1, 1, 5); step();
        rd(1, 0, 5); rd(1, 1, 5); step();
        // dut1 keeps its contents across reset.
        wr(1, 40, 8'hAA); step();
        step(); step();
        reset_duts(2'b10, 2);
        rd(1, 0, 40); rd(1, 1, 17); step();

        // dut0 lockout: writes and reads through the end of the sweep are ignored.
        while (rem[0] > 0) begin
            wr(0, 10, 8'hFF); rd(0, 0, 10); rd(0, 1, 10); step();
        end
        rd(0, 0, 10); rd(0, 1, 10); step();

        // dut0 basic, dual channel, read-during-write (old data).
        wr(0, 17, 8'h5C); step();
        rd(0, 0, 17); step();
        wr(0, 3, 8'h11); step();
        wr(0, 300, 8'hEE); step();
        rd(0, 0, 3); rd(0, 1, 300); step();
        wr(0, 5, 8'h01); step();
        wr(0, 5, 8'h02); rd(0, 0, 5); rd(0, 1, 5); step();
        rd(0, 0, 5); rd(0, 1, 5); step();

        // Fill with 8'hAA, reading each word back a cycle later.
        for (int a = 0; a < int'(DEPTH); a++) begin
            wr(0, a, 8'hAA);
            if (a > 0) rd(0, 1, a - 1);
            step();
        end
        step(); step();

        // Clear, reset again mid-sweep, then check the full array reads zero.
        reset_duts(2'b01, 2);
        repeat (200) step();
        reset_duts(2'b01, 2);
        while (rem[0] > 0) step();
        for (int a = 0; a < int'(DEPTH); a++) begin
            rd(0, 0, a); rd(0, 1, int'(DEPTH) - 1 - a); step();
        end
        repeat (4) step();

        for (int i = 0; i < 4; i++) chk("drain", i, 32'(sb[2'(i)].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
